// File: rtl/rtsnoc_pkg.sv
// Shared RTSNoC definitions: packet field layout, bus sizing and local-port addresses.
package rtsnoc_pkg;

    localparam int unsigned LocalWidth = 3;

    // Local router port addresses
    localparam logic [2:0] LocalNn = 3'd0;
    localparam logic [2:0] LocalNe = 3'd1;
    localparam logic [2:0] LocalEe = 3'd2;
    localparam logic [2:0] LocalSe = 3'd3;
    localparam logic [2:0] LocalSs = 3'd4;
    localparam logic [2:0] LocalSw = 3'd5;
    localparam logic [2:0] LocalWw = 3'd6;
    localparam logic [2:0] LocalNw = 3'd7;

    typedef enum logic {StIdle, StPulse} rx_state_e;

    function automatic int unsigned bus_size(int unsigned data_w, int unsigned sx, int unsigned sy);
        return data_w + 2 * LocalWidth + 2 * sx + 2 * sy;
    endfunction

    // Layout, MSB to LSB: {X_orig, Y_orig, local_orig, X_dst, Y_dst, local_dst, data}
    function automatic int unsigned off_data();
        return 0;
    endfunction

    function automatic int unsigned off_local_dst(int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned off_y_dst(int unsigned data_w);
        return data_w + LocalWidth;
    endfunction

    function automatic int unsigned off_x_dst(int unsigned data_w, int unsigned sy);
        return data_w + LocalWidth + sy;
    endfunction

    function automatic int unsigned off_local_orig(int unsigned data_w, int unsigned sx,
                                                   int unsigned sy);
        return data_w + LocalWidth + sy + sx;
    endfunction

    function automatic int unsigned off_y_orig(int unsigned data_w, int unsigned sx,
                                               int unsigned sy);
        return data_w + 2 * LocalWidth + sy + sx;
    endfunction

    function automatic int unsigned off_x_orig(int unsigned data_w, int unsigned sx,
                                               int unsigned sy);
        return data_w + 2 * LocalWidth + 2 * sy + sx;
    endfunction

endpackage

// File: rtl/rtsnoc_sync_fifo.sv
// Show-ahead synchronous FIFO; head entry is always presented on rdata_o.
module rtsnoc_sync_fifo #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   level_o
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LevelFull = (DEPTH_LOG2 + 1)'(Depth);

    logic [WIDTH-1:0]      mem [Depth];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  do_push, do_pop;

    assign full_o  = (level_q == LevelFull);
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        level_d = level_q;
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    // Storage is not reset; contents are only observable through a valid level.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/rtsnoc_rx_buffer.sv
// Receive elastic buffer: drains the router local port, drops misrouted packets and
// re-presents accepted packets to the node with the router's dout/nd/rd handshake.
module rtsnoc_rx_buffer
    import rtsnoc_pkg::*;
#(
    parameter int unsigned NOC_DATA_WIDTH = 32,
    parameter int unsigned SOC_SIZE_X     = 1,
    parameter int unsigned SOC_SIZE_Y     = 1,
    parameter logic [2:0]  NOC_LOCAL_ADR  = 3'd0,
    parameter int unsigned NOC_X          = 0,
    parameter int unsigned NOC_Y          = 0,
    parameter int unsigned DEPTH_LOG2     = 2,
    localparam int unsigned BUS = bus_size(NOC_DATA_WIDTH, SOC_SIZE_X, SOC_SIZE_Y)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [BUS-1:0]        rtr_dout_i,
    input  logic                  rtr_nd_i,
    output logic                  rtr_rd_o,
    output logic [BUS-1:0]        node_dout_o,
    output logic                  node_nd_o,
    input  logic                  node_rd_i,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic [7:0]            drop_cnt_o
);

    localparam int unsigned OffLocalDst = off_local_dst(NOC_DATA_WIDTH);
    localparam int unsigned OffYDst     = off_y_dst(NOC_DATA_WIDTH);
    localparam int unsigned OffXDst     = off_x_dst(NOC_DATA_WIDTH, SOC_SIZE_Y);
    localparam logic [SOC_SIZE_X-1:0] MyX = SOC_SIZE_X'(NOC_X);
    localparam logic [SOC_SIZE_Y-1:0] MyY = SOC_SIZE_Y'(NOC_Y);

    rx_state_e state_q, state_d;
    logic [7:0] drop_cnt_q;
    logic       dst_match, push, drop, fifo_full, fifo_empty;

    assign dst_match = (rtr_dout_i[OffXDst +: SOC_SIZE_X] == MyX)
                    && (rtr_dout_i[OffYDst +: SOC_SIZE_Y] == MyY)
                    && (rtr_dout_i[OffLocalDst +: LocalWidth] == NOC_LOCAL_ADR);

    // StPulse is the registered rd pulse and doubles as the one-cycle accept blackout.
    always_comb begin
        state_d = StIdle;
        push    = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rtr_nd_i) begin
                    if (!dst_match) begin
                        drop    = 1'b1;
                        state_d = StPulse;
                    end else if (!fifo_full) begin
                        push    = 1'b1;
                        state_d = StPulse;
                    end
                end
            end
            StPulse: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            drop_cnt_q <= 8'd0;
        end else begin
            state_q <= state_d;
            if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    rtsnoc_sync_fifo #(
        .WIDTH      (BUS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .wdata_i (rtr_dout_i),
        .pop_i   (node_rd_i),
        .rdata_o (node_dout_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    assign rtr_rd_o   = (state_q == StPulse);
    assign node_nd_o  = !fifo_empty;
    assign drop_cnt_o = drop_cnt_q;

endmodule
